button_event_arbiter: RTL and testbench

Front-end controller for the board's push-buttons. It takes N_BUTTONS raw, active-low, bouncing button inputs and synchronizes each one. Each button is debounced by its own synthesizable counter FSM. Each debounced press becomes a one-shot event. Pending events are round-robin arbitrated onto a single valid/ready event channel that carries the button index to downstream control logic.

---
 rtl/debounce_pkg.sv | 17 +
 rtl/debounce_channel.sv | 86 ++++++++
 rtl/button_event_arbiter.sv | 70 +++++++
 tb/tb_button_event_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared state encodings and sizing helpers for the push-button front end.
package debounce_pkg;

  localparam logic [1:0] IDLE          = 2'd0;
  localparam logic [1:0] COUNT_PRESS   = 2'd1;
  localparam logic [1:0] PRESSED       = 2'd2;
  localparam logic [1:0] COUNT_RELEASE = 2'd3;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button: synchronizer, stable-run debounce FSM and the press strobe.
module debounce_channel import debounce_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 5,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic noisy,
  output logic press_pulse
);

  localparam int            CW       = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES);
  // With a single-sample debounce the first differing sample already completes the run.
  localparam bit            SINGLE   = (DEBOUNCE_CYCLES == 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [1:0]             state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt, cnt_inc;

  always_ff @(posedge clk or posedge reset)
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], noisy};

  assign sync    = sync_q[SYNC_STAGES-1];
  assign cnt_inc = cnt + CNT_ONE;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (!sync) begin
        state_nxt = SINGLE ? PRESSED : COUNT_PRESS;
        cnt_nxt   = SINGLE ? '0 : CNT_ONE;
      end
      COUNT_PRESS:
        if (sync) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt_inc == CNT_DONE) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else cnt_nxt = cnt_inc;
      PRESSED: if (sync) begin
        state_nxt = SINGLE ? IDLE : COUNT_RELEASE;
        cnt_nxt   = SINGLE ? '0 : CNT_ONE;
      end
      COUNT_RELEASE:
        if (!sync) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt_inc == CNT_DONE) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else cnt_nxt = cnt_inc;
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // High during the cycle whose closing edge commits the press; the top captures it
  // into its pending flop on that same edge. Driven from flops only.
  always_comb begin
    press_pulse = 1'b0;
    if (!sync)
      case (state)
        IDLE:        press_pulse = SINGLE;
        COUNT_PRESS: press_pulse = (cnt_inc == CNT_DONE);
        default:     press_pulse = 1'b0;
      endcase
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Debounced button presses become pending events, round-robin granted onto a
// 1-deep valid/ready slot carrying the button index.
module button_event_arbiter import debounce_pkg::*; #(
  parameter int N_BUTTONS       = 4,
  parameter int DEBOUNCE_CYCLES = 5,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_BUTTONS-1:0]         noisy_buttons,
  input  logic                         evt_ready,
  output logic                         evt_valid,
  output logic [id_w(N_BUTTONS)-1:0]   evt_id,
  output logic                         overflow,
  output logic [N_BUTTONS-1:0]         pending
);

  localparam int ID_W = id_w(N_BUTTONS);

  logic [N_BUTTONS-1:0] press_pulse, grant_oh;
  logic [ID_W-1:0]      rr_ptr, pick;
  logic                 load;

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .noisy       (noisy_buttons[g]),
      .press_pulse (press_pulse[g])
    );
  end

  // Walk offsets from the top down so the lowest offset from rr_ptr wins.
  always_comb begin
    int j;
    pick = '0;
    for (int i = N_BUTTONS - 1; i >= 0; i--) begin
      j = int'(rr_ptr) + i;
      if (j >= N_BUTTONS) j = j - N_BUTTONS;
      if (pending[ID_W'(j)]) pick = ID_W'(j);
    end
  end

  assign load     = (!evt_valid || evt_ready) && (|pending);
  assign grant_oh = load ? ({{(N_BUTTONS-1){1'b0}}, 1'b1} << pick) : '0;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pending   <= '0;
      overflow  <= 1'b0;
      rr_ptr    <= '0;
      evt_valid <= 1'b0;
      evt_id    <= '0;
    end else begin
      // A press landing on the edge its own bit is granted re-arms it without loss.
      pending  <= (pending & ~grant_oh) | press_pulse;
      overflow <= |(press_pulse & pending & ~grant_oh);
      if (load) begin
        evt_valid <= 1'b1;
        evt_id    <= pick;
        rr_ptr    <= (pick == ID_W'(N_BUTTONS - 1)) ? '0 : pick + ID_W'(1);
      end else if (evt_ready) begin
        evt_valid <= 1'b0;
      end
    end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Scenario tasks plus a randomized run, checked cycle by cycle against a
// behavioural model of debounce runs, pending events and round-robin grants.
module tb_button_event_arbiter;

  localparam int N = 4, D = 5, S = 2, ID_W = 2;

  logic            clk = 1'b0, reset = 1'b0, evt_ready = 1'b0;
  logic [N-1:0]    noisy_buttons = '1;
  logic            evt_valid, overflow;
  logic [ID_W-1:0] evt_id;
  logic [N-1:0]    pending;

  int n_cmp = 0, n_err = 0;
  logic [ID_W-1:0] hs_q[$];

  always #5 clk = ~clk;

  button_event_arbiter #(.N_BUTTONS(N), .DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .noisy_buttons(noisy_buttons), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_id(evt_id), .overflow(overflow), .pending(pending)
  );

  // Reference model: a level is accepted after D consecutive differing samples.
  logic [N-1:0]    m_pend;
  logic            m_valid, m_ovf;
  logic [ID_W-1:0] m_id;
  int              m_rr;
  bit              m_sh [N][S];
  bit              m_lvl[N];
  int              m_run[N];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pend = '0; m_valid = 0; m_ovf = 0; m_id = '0; m_rr = 0;
      for (int b = 0; b < N; b++) begin
        m_lvl[b] = 1; m_run[b] = 0;
        for (int s = 0; s < S; s++) m_sh[b][s] = 1;
      end
    end else begin : step
      bit fire[N];
      bit take, smp;
      int grant;
      grant = -1;
      take  = (!m_valid || evt_ready) && (m_pend != 0);
      if (take)
        for (int k = 0; k < N; k++)
          if (grant < 0 && m_pend[(m_rr + k) % N]) grant = (m_rr + k) % N;
      for (int b = 0; b < N; b++) begin
        smp = m_sh[b][S-1];
        for (int s = S - 1; s > 0; s--) m_sh[b][s] = m_sh[b][s-1];
        m_sh[b][0] = noisy_buttons[b];
        fire[b] = 0;
        if (smp == m_lvl[b]) m_run[b] = 0;
        else begin
          m_run[b]++;
          if (m_run[b] == D) begin m_lvl[b] = smp; m_run[b] = 0; fire[b] = !smp; end
        end
      end
      m_ovf = 0;
      if (take) begin
        m_pend[grant] = 0; m_valid = 1; m_id = ID_W'(grant); m_rr = (grant + 1) % N;
      end else if (m_valid && evt_ready) m_valid = 0;
      for (int b = 0; b < N; b++)
        if (fire[b]) begin
          if (m_pend[b]) m_ovf = 1;
          m_pend[b] = 1;
        end
    end
  end

  always @(posedge clk)
    if (!reset && evt_valid === 1'b1 && evt_ready === 1'b1) hs_q.push_back(evt_id);

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if ({evt_valid, evt_id, overflow, pending} !== '0) begin
      n_err++; $display("FAIL reset_outputs got %b want 0", {evt_valid, evt_id, overflow, pending});
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({evt_valid, evt_id, overflow, pending} !== {m_valid, m_id, m_ovf, m_pend}) begin
        n_err++; $display("FAIL reset_idle t=%0t got %b want %b", $time,
          {evt_valid, evt_id, overflow, pending}, {m_valid, m_id, m_ovf, m_pend});
      end
    end
  endtask

  task automatic test_simultaneous();
    int vcnt = 0;
    hs_q.delete();
    evt_ready = 1'b0;
    noisy_buttons[0] = 0; noisy_buttons[1] = 0; noisy_buttons[3] = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({evt_valid, evt_id, overflow, pending} !== {m_valid, m_id, m_ovf, m_pend}) begin
        n_err++; $display("FAIL simul_model t=%0t got %b want %b", $time,
          {evt_valid, evt_id, overflow, pending}, {m_valid, m_id, m_ovf, m_pend});
      end
      n_cmp++;
      if (evt_valid !== (k >= 7) || (evt_valid && evt_id !== 2'd0)) begin
        n_err++; $display("FAIL simul_hold k=%0d got v=%b id=%0d want v=%b id=0", k, evt_valid, evt_id, k >= 7);
      end
    end
    evt_ready = 1'b1;
    noisy_buttons = '1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (evt_valid) vcnt++;
      n_cmp++;
      if ({evt_valid, evt_id, overflow, pending} !== {m_valid, m_id, m_ovf, m_pend}) begin
        n_err++; $display("FAIL simul_drain t=%0t got %b want %b", $time,
          {evt_valid, evt_id, overflow, pending}, {m_valid, m_id, m_ovf, m_pend});
      end
    end
    n_cmp++;
    if (hs_q.size() != 3 || hs_q[0] !== 2'd0 || hs_q[1] !== 2'd1 || hs_q[2] !== 2'd3 || vcnt != 2) begin
      n_err++; $display("FAIL simul_order got %p (valid cycles after ready %0d) want '{0,1,3} and 2", hs_q, vcnt);
    end
  endtask

  task automatic test_rr_wrap();
    hs_q.delete();
    evt_ready = 1'b1;
    noisy_buttons[3] = 0; noisy_buttons[0] = 0;
    for (int k = 0; k < 45; k++) begin
      if (k == 25) noisy_buttons = '1;
      @(negedge clk);
      n_cmp++;
      if ({evt_valid, evt_id, overflow, pending} !== {m_valid, m_id, m_ovf, m_pend}) begin
        n_err++; $display("FAIL rr_model t=%0t got %b want %b", $time,
          {evt_valid, evt_id, overflow, pending}, {m_valid, m_id, m_ovf, m_pend});
      end
    end
    n_cmp++;
    if (hs_q.size() != 2 || hs_q[0] !== 2'd0 || hs_q[1] !== 2'd3) begin
      n_err++; $display("FAIL rr_order got %p want '{0,3}", hs_q);
    end
  endtask

  task automatic test_clean_press();
    hs_q.delete();
    evt_ready = 1'b1;
    noisy_buttons[2] = 0;
    for (int k = 0; k < 50; k++) begin
      if (k == 20) noisy_buttons[2] = 1;
      @(negedge clk);
      n_cmp++;
      if ({evt_valid, evt_id, overflow, pending} !== {m_valid, m_id, m_ovf, m_pend}) begin
        n_err++; $display("FAIL clean_model t=%0t got %b want %b", $time,
          {evt_valid, evt_id, overflow, pending}, {m_valid, m_id, m_ovf, m_pend});
      end
      n_cmp++;
      if (evt_valid !== (k == 7) || pending[2] !== (k == 6) || (k == 7 && evt_id !== 2'd2)) begin
        n_err++; $display("FAIL clean_latency k=%0d got v=%b p2=%b id=%0d want v=%b p2=%b id=2",
          k, evt_valid, pending[2], evt_id, k == 7, k == 6);
      end
    end
    n_cmp++;
    if (hs_q.size() != 1 || hs_q[0] !== 2'd2) begin
      n_err++; $display("FAIL clean_count got %p want '{2}", hs_q);
    end
  endtask

  task automatic test_bounce();
    bit pat[$];
    hs_q.delete();
    evt_ready = 1'b1;
    repeat (3) pat.push_back(0); pat.push_back(1);
    repeat (3) pat.push_back(0);
    repeat (10) pat.push_back(1);
    repeat (10) pat.push_back(0);
    repeat (20) pat.push_back(1);
    for (int c = 0; c < pat.size(); c++) begin
      noisy_buttons[0] = pat[c];
      @(negedge clk);
      n_cmp++;
      if ({evt_valid, evt_id, overflow, pending} !== {m_valid, m_id, m_ovf, m_pend}) begin
        n_err++; $display("FAIL bounce_model t=%0t got %b want %b", $time,
          {evt_valid, evt_id, overflow, pending}, {m_valid, m_id, m_ovf, m_pend});
      end
      if (c < 17) begin
        n_cmp++;
        if (pending !== '0 || evt_valid !== 1'b0) begin
          n_err++; $display("FAIL bounce_glitch c=%0d got pend=%b v=%b want 0", c, pending, evt_valid);
        end
      end
    end
    n_cmp++;
    if (hs_q.size() != 1 || hs_q[0] !== 2'd0) begin
      n_err++; $display("FAIL bounce_count got %p want '{0}", hs_q);
    end
  endtask

  task automatic test_overflow();
    int ovf_seen = 0;
    hs_q.delete();
    evt_ready = 1'b0;
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 22; k++) begin
        noisy_buttons[1] = (k >= 10);
        @(negedge clk);
        if (overflow === 1'b1) ovf_seen++;
        n_cmp++;
        if ({evt_valid, evt_id, overflow, pending} !== {m_valid, m_id, m_ovf, m_pend}) begin
          n_err++; $display("FAIL ovf_model t=%0t got %b want %b", $time,
            {evt_valid, evt_id, overflow, pending}, {m_valid, m_id, m_ovf, m_pend});
        end
      end
    n_cmp++;
    if (ovf_seen != 1 || evt_valid !== 1'b1 || evt_id !== 2'd1 || pending !== 4'b0010) begin
      n_err++; $display("FAIL ovf_state got ovf=%0d v=%b id=%0d pend=%b want 1 1 1 0010",
        ovf_seen, evt_valid, evt_id, pending);
    end
    evt_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({evt_valid, evt_id, overflow, pending} !== {m_valid, m_id, m_ovf, m_pend}) begin
        n_err++; $display("FAIL ovf_drain t=%0t got %b want %b", $time,
          {evt_valid, evt_id, overflow, pending}, {m_valid, m_id, m_ovf, m_pend});
      end
    end
    n_cmp++;
    if (hs_q.size() != 2 || hs_q[0] !== 2'd1 || hs_q[1] !== 2'd1 || evt_valid !== 1'b0) begin
      n_err++; $display("FAIL ovf_count got %p v=%b want '{1,1} v=0", hs_q, evt_valid);
    end
  endtask

  task automatic test_reset_mid();
    hs_q.delete();
    evt_ready = 1'b0;
    noisy_buttons[2] = 0;
    for (int k = 0; k < 14; k++) begin
      if (k == 10) noisy_buttons[3] = 0;
      @(negedge clk);
      n_cmp++;
      if ({evt_valid, evt_id, overflow, pending} !== {m_valid, m_id, m_ovf, m_pend}) begin
        n_err++; $display("FAIL rmid_model t=%0t got %b want %b", $time,
          {evt_valid, evt_id, overflow, pending}, {m_valid, m_id, m_ovf, m_pend});
      end
    end
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin
      n_err++; $display("FAIL rmid_pre got v=%b id=%0d want 1 2", evt_valid, evt_id);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({evt_valid, evt_id, overflow, pending} !== '0) begin
      n_err++; $display("FAIL rmid_async got %b want 0", {evt_valid, evt_id, overflow, pending});
    end
    noisy_buttons[2] = 1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      n_cmp++;
      if (evt_valid !== (k >= 7) || (evt_valid && evt_id !== 2'd3)) begin
        n_err++; $display("FAIL rmid_held k=%0d got v=%b id=%0d want v=%b id=3", k, evt_valid, evt_id, k >= 7);
      end
      n_cmp++;
      if ({evt_valid, evt_id, overflow, pending} !== {m_valid, m_id, m_ovf, m_pend}) begin
        n_err++; $display("FAIL rmid_model2 t=%0t got %b want %b", $time,
          {evt_valid, evt_id, overflow, pending}, {m_valid, m_id, m_ovf, m_pend});
      end
    end
    evt_ready = 1'b1;
    noisy_buttons[3] = 1;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (hs_q.size() != 1 || hs_q[0] !== 2'd3) begin
      n_err++; $display("FAIL rmid_count got %p want '{3}", hs_q);
    end
  endtask

  task automatic test_random();
    bit tgt[N];
    for (int b = 0; b < N; b++) tgt[b] = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 29) == 0) tgt[b] = !tgt[b];
        noisy_buttons[b] = tgt[b] ^ ($urandom_range(0, 11) == 0);
      end
      evt_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      n_cmp++;
      if ({evt_valid, evt_id, overflow, pending} !== {m_valid, m_id, m_ovf, m_pend}) begin
        n_err++; $display("FAIL random_model t=%0t got %b want %b", $time,
          {evt_valid, evt_id, overflow, pending}, {m_valid, m_id, m_ovf, m_pend});
      end
    end
    noisy_buttons = '1;
    evt_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({evt_valid, evt_id, overflow, pending} !== {m_valid, m_id, m_ovf, m_pend}) begin
        n_err++; $display("FAIL random_drain t=%0t got %b want %b", $time,
          {evt_valid, evt_id, overflow, pending}, {m_valid, m_id, m_ovf, m_pend});
      end
    end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_rr_wrap();
    test_clean_press();
    test_bounce();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
